// File: rtl/bcd_encoder_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_encoder_seq_if
// Brief    : Valid/ready handshake bundle for the bcd_encoder_seq converter.
//            The master drives words in and accepts results; the slave is
//            the converter itself.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_encoder_seq_if #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
);
  logic                 i_valid;
  logic                 o_ready;
  logic [DATA_W:0]      i_b_val;
  logic                 o_valid;
  logic                 i_ready;
  logic [DIGITS:0][3:0] o_data;
  logic                 o_ovf;

  modport master (
    output i_valid, i_b_val, i_ready,
    input  o_ready, o_valid, o_data, o_ovf
  );

  modport slave (
    input  i_valid, i_b_val, i_ready,
    output o_ready, o_valid, o_data, o_ovf
  );
endinterface
`default_nettype wire

// File: rtl/bcd_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_encoder_seq
// Brief    : Multi-cycle binary to packed-BCD converter (shift/add-3, one
//            bit per clock) with a sign nibble on top and sticky decimal
//            overflow. Sign-magnitude or two's-complement input.
// Options  : BCD_NEG_ZERO_FIX_EN - when defined, a zero magnitude always
//            reports the positive sign nibble (suppresses SM "-0").
// Revision : 1.0 - initial release
// ============================================================================
module bcd_encoder_seq #(
  parameter int DATA_W      = 8,
  parameter int DIGITS      = 3,
  parameter int SIGNED_MODE = 0
) (
  input  wire logic          iClk,
  input  wire logic          iReset,
  bcd_encoder_seq_if.slave   bus
);

  // In 2C mode the magnitude needs one extra bit so -2^DATA_W fits.
  localparam int          MAG_W    = DATA_W + SIGNED_MODE;
  localparam int          CNT_W    = $clog2(MAG_W + 1);
  localparam int          DIG_W    = 4 * DIGITS;
  localparam logic [3:0]  SIGN_POS = 4'b1100;
  localparam logic [3:0]  SIGN_NEG = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [MAG_W-1:0]     mag_q, mag_d;
  logic [DIG_W-1:0]     dig_q, dig_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic                 ovf_q, ovf_d;
  logic [DIGITS:0][3:0] data_q, data_d;
  logic                 ovf_out_q, ovf_out_d;

  logic                 in_sign;
  logic [MAG_W-1:0]     in_mag;
  logic                 acc_sign;
  logic [DIG_W-1:0]     adj;

  // Split the incoming word into sign and unsigned magnitude.
  always_comb begin
    in_sign = bus.i_b_val[DATA_W];
    if (SIGNED_MODE != 0) begin
      in_mag = in_sign ? MAG_W'(-bus.i_b_val) : MAG_W'(bus.i_b_val);
    end else begin
      in_mag = MAG_W'(bus.i_b_val[DATA_W-1:0]);
    end
`ifdef BCD_NEG_ZERO_FIX_EN
    acc_sign = in_sign && (in_mag != '0);
`else
    acc_sign = in_sign;
`endif
  end

  // Add-3 correction on every digit that is 5 or more before the shift.
  always_comb begin
    adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    data_d    = data_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          sign_d  = acc_sign;
          mag_d   = in_mag;
          dig_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(MAG_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          dig_d = {adj[DIG_W-2:0], mag_q[MAG_W-1]};
          mag_d = mag_q << 1;
          if (adj[DIG_W-1]) begin
            ovf_d = 1'b1;
          end
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Results are published only here, so they stay put otherwise.
          data_d    = {(sign_q ? SIGN_NEG : SIGN_POS), dig_q};
          ovf_out_d = ovf_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
      data_q    <= data_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  // Ready is held low for the whole time reset is asserted.
  assign bus.o_ready = (state_q == IDLE) && !iReset;
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_data  = data_q;
  assign bus.o_ovf   = ovf_out_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_encoder_seq
// Brief    : Directed self-checking bench for bcd_encoder_seq. Three
//            instances: SM 3-digit, 2C 3-digit, SM 2-digit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_encoder_seq;

`ifdef BCD_NEG_ZERO_FIX_EN
  localparam logic [15:0] SM_NEG_ZERO = 16'hC000;
`else
  localparam logic [15:0] SM_NEG_ZERO = 16'hD000;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  bcd_encoder_seq_if #(.DATA_W(8), .DIGITS(3)) if_sm ();
  bcd_encoder_seq_if #(.DATA_W(8), .DIGITS(3)) if_2c ();
  bcd_encoder_seq_if #(.DATA_W(8), .DIGITS(2)) if_d2 ();

  bcd_encoder_seq #(.DATA_W(8), .DIGITS(3), .SIGNED_MODE(0)) u_sm (
    .iClk(clk), .iReset(rst), .bus(if_sm)
  );
  bcd_encoder_seq #(.DATA_W(8), .DIGITS(3), .SIGNED_MODE(1)) u_2c (
    .iClk(clk), .iReset(rst), .bus(if_2c)
  );
  bcd_encoder_seq #(.DATA_W(8), .DIGITS(2), .SIGNED_MODE(0)) u_d2 (
    .iClk(clk), .iReset(rst), .bus(if_d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input int sel, input logic v, input logic [8:0] val);
    case (sel)
      0: begin if_sm.i_valid = v; if_sm.i_b_val = val; end
      1: begin if_2c.i_valid = v; if_2c.i_b_val = val; end
      default: begin if_d2.i_valid = v; if_d2.i_b_val = val; end
    endcase
  endtask

  function automatic logic dut_valid(input int sel);
    case (sel)
      0: return if_sm.o_valid;
      1: return if_2c.o_valid;
      default: return if_d2.o_valid;
    endcase
  endfunction

  function automatic logic dut_ready(input int sel);
    case (sel)
      0: return if_sm.o_ready;
      1: return if_2c.o_ready;
      default: return if_d2.o_ready;
    endcase
  endfunction

  function automatic logic [15:0] dut_data(input int sel);
    case (sel)
      0: return if_sm.o_data;
      1: return if_2c.o_data;
      default: return {4'h0, if_d2.o_data};
    endcase
  endfunction

  function automatic logic dut_ovf(input int sel);
    case (sel)
      0: return if_sm.o_ovf;
      1: return if_2c.o_ovf;
      default: return if_d2.o_ovf;
    endcase
  endfunction

  // Send one word, wait for the result (bounded) and return the latency.
  task automatic send_wait(input int sel, input logic [8:0] val, input string tag, output int lat);
    bit got;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(dut_ready(sel)), 32'd1);
    drive(sel, 1'b1, val);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 9'h000);
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (dut_valid(sel)) got = 1;
    end
  endtask

  task automatic run_word(input int sel, input logic [8:0] val, input logic [15:0] exp_data,
                          input logic exp_ovf, input int exp_lat, input string tag);
    int lat;
    send_wait(sel, val, tag, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, 32'(dut_data(sel)), 32'(exp_data));
    chk({tag, "_ovf"}, 32'(dut_ovf(sel)), 32'(exp_ovf));
    @(posedge clk);
    #1;
    chk({tag, "_vld_drop"}, 32'(dut_valid(sel)), 32'd0);
  endtask

  initial begin
    int lat;
    int extra;
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 9'h000);
    if_sm.i_ready = 1'b1;
    if_2c.i_ready = 1'b1;
    if_d2.i_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(if_sm.o_ready), 32'd0);
    chk("rst_vld", 32'(if_sm.o_valid), 32'd0);
    chk("rst_data", 32'(if_sm.o_data), 32'd0);
    chk("rst_ovf", 32'(if_sm.o_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 32'(if_sm.o_ready), 32'd1);

    // Sign-magnitude, 3 digits
    run_word(0, 9'h0FF, 16'hC255, 1'b0, 9, "sm_p255");
    run_word(0, 9'h1FF, 16'hD255, 1'b0, 9, "sm_n255");
    run_word(0, 9'h000, 16'hC000, 1'b0, 9, "sm_zero");
    run_word(0, 9'h100, SM_NEG_ZERO, 1'b0, 9, "sm_negzero");

    // Two's complement, 3 digits
    run_word(1, 9'h100, 16'hD256, 1'b0, 10, "tc_min");
    run_word(1, 9'h1FF, 16'hD001, 1'b0, 10, "tc_m1");
    run_word(1, 9'h0FF, 16'hC255, 1'b0, 10, "tc_p255");

    // 2 digits: overflow and downstream stall
    if_d2.i_ready = 1'b0;
    send_wait(2, 9'h07B, "d2_ovf", lat);
    chk("d2_ovf_lat", 32'(lat), 32'd9);
    chk("d2_ovf_data", 32'(if_d2.o_data), 32'h0C23);
    chk("d2_ovf_flag", 32'(if_d2.o_ovf), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(2, 1'b1, 9'h005);
      chk("stall_vld", 32'(if_d2.o_valid), 32'd1);
      chk("stall_data", 32'(if_d2.o_data), 32'h0C23);
      chk("stall_rdy", 32'(if_d2.o_ready), 32'd0);
    end
    @(negedge clk);
    drive(2, 1'b0, 9'h000);
    if_d2.i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_vld", 32'(if_d2.o_valid), 32'd0);
    chk("rel_hold", 32'(if_d2.o_data), 32'h0C23);
    chk("rel_rdy", 32'(if_d2.o_ready), 32'd1);
    run_word(2, 9'h063, 16'h0C99, 1'b0, 9, "d2_99");

    // Reset in the 4th SHIFT cycle discards the word
    @(negedge clk);
    drive(0, 1'b1, 9'h0FF);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 9'h000);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(if_sm.o_valid), 32'd0);
    chk("mid_rst_data", 32'(if_sm.o_data), 32'd0);
    chk("mid_rst_2c_data", 32'(if_2c.o_data), 32'd0);
    chk("mid_rst_rdy", 32'(if_sm.o_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if_sm.o_valid) extra++;
    end
    chk("no_ghost_vld", 32'(extra), 32'd0);
    run_word(0, 9'h02A, 16'hC042, 1'b0, 9, "sm_42");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
